// File: rtl/echo_sched.sv
// Echo scheduler: passes live note events straight to the voice logic and
// replays each one as a train of decaying echo taps held in a small table
// of pending entries, timed against a tick-driven timestamp.
module echo_sched #(
   parameter int SLOTS = 8,
   parameter int TW    = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          tick,
   input  logic [TW-1:0] delay,
   input  logic [1:0]    repeats,
   input  logic          ev_valid,
   output logic          ev_ready,
   input  logic          ev_on,
   input  logic [6:0]    ev_note,
   input  logic [6:0]    ev_vel,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_on,
   output logic [6:0]    out_note,
   output logic [6:0]    out_vel,
   output logic          out_echo,
   output logic [7:0]    drop_cnt
);

   localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

   // timestamp
   logic [TW-1:0]    now_q, now_d;

   // pending echo table
   logic [SLOTS-1:0] valid_q, valid_d;
   logic [SLOTS-1:0] on_q, on_d;
   logic [TW-1:0]    due_q  [SLOTS];
   logic [TW-1:0]    due_d  [SLOTS];
   logic [6:0]       note_q [SLOTS];
   logic [6:0]       note_d [SLOTS];
   logic [6:0]       vel_q  [SLOTS];
   logic [6:0]       vel_d  [SLOTS];
   logic [1:0]       left_q [SLOTS];
   logic [1:0]       left_d [SLOTS];

   // output register and drop counter
   logic             out_valid_q, out_valid_d;
   logic             out_on_q, out_on_d;
   logic [6:0]       out_note_q, out_note_d;
   logic [6:0]       out_vel_q, out_vel_d;
   logic             out_echo_q, out_echo_d;
   logic [7:0]       drop_q, drop_d;

   // decision signals
   logic             slot_free;
   logic             live_acc;
   logic             wants_entry;
   logic             keep_entry;
   logic [TW-1:0]    dly_eff;
   logic [6:0]       ev_vel_half;
   logic [6:0]       tap_vel_half;
   logic [SLOTS-1:0] is_due;
   logic             due_hit;
   logic [IW-1:0]    due_idx;
   logic             free_hit;
   logic [IW-1:0]    free_idx;

   // An entry is due once now has reached or passed its due time; the
   // half-range window keeps late entries firing across a timestamp wrap.
   for (genvar g = 0; g < SLOTS; g++) begin : g_due
      logic [TW-1:0] age;
      assign age       = now_q - due_q[g];
      assign is_due[g] = valid_q[g] && !age[TW-1];
   end

   // Shared handshake and arithmetic terms.
   always_comb begin
      slot_free    = !out_valid_q || out_ready;
      live_acc     = ev_valid && en && slot_free;
      dly_eff      = (delay == '0) ? TW'(1) : delay;
      ev_vel_half  = ev_vel >> 1;
      wants_entry  = (repeats != 2'd0) && (!ev_on || (ev_vel_half != 7'd0));
   end

   // Lowest-index due entry (emission order) and lowest-index empty entry.
   always_comb begin
      due_hit  = 1'b0;
      due_idx  = '0;
      free_hit = 1'b0;
      free_idx = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (is_due[i]) begin
            due_hit = 1'b1;
            due_idx = IW'(i);
         end
         if (!valid_q[i]) begin
            free_hit = 1'b1;
            free_idx = IW'(i);
         end
      end
   end

   // Decide whether the tap just fired should be re-armed for another tap.
   always_comb begin
      tap_vel_half = vel_q[due_idx] >> 1;
      keep_entry   = (left_q[due_idx] != 2'd0) &&
                     (!on_q[due_idx] || (tap_vel_half != 7'd0));
   end

   // Next-state for timestamp, table, output register and drop counter.
   always_comb begin
      now_d       = now_q;
      valid_d     = valid_q;
      on_d        = on_q;
      due_d       = due_q;
      note_d      = note_q;
      vel_d       = vel_q;
      left_d      = left_q;
      out_valid_d = out_valid_q && !out_ready;
      out_on_d    = out_on_q;
      out_note_d  = out_note_q;
      out_vel_d   = out_vel_q;
      out_echo_d  = out_echo_q;
      drop_d      = drop_q;

      if (en && tick) begin
         now_d = now_q + TW'(1);
      end

      if (!en) begin
         // halted: pending echoes are flushed, only a held output may drain
         valid_d = '0;
      end else if (live_acc) begin
         out_valid_d = 1'b1;
         out_on_d    = ev_on;
         out_note_d  = ev_note;
         out_vel_d   = ev_vel;
         out_echo_d  = 1'b0;
         if (wants_entry) begin
            if (free_hit) begin
               valid_d[free_idx] = 1'b1;
               on_d[free_idx]    = ev_on;
               due_d[free_idx]   = now_q + dly_eff;
               note_d[free_idx]  = ev_note;
               vel_d[free_idx]   = ev_vel_half;
               left_d[free_idx]  = repeats - 2'd1;
            end else if (drop_q != 8'hFF) begin
               drop_d = drop_q + 8'd1;
            end
         end
      end else if (slot_free && due_hit) begin
         out_valid_d = 1'b1;
         out_on_d    = on_q[due_idx];
         out_note_d  = note_q[due_idx];
         out_vel_d   = vel_q[due_idx];
         out_echo_d  = 1'b1;
         if (keep_entry) begin
            // step from the old due time so late taps keep their spacing
            due_d[due_idx]  = due_q[due_idx] + dly_eff;
            vel_d[due_idx]  = tap_vel_half;
            left_d[due_idx] = left_q[due_idx] - 2'd1;
         end else begin
            valid_d[due_idx] = 1'b0;
         end
      end
   end

   // State registers; reset discards pending echoes and any held output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         now_q       <= '0;
         valid_q     <= '0;
         on_q        <= '0;
         for (int i = 0; i < SLOTS; i++) begin
            due_q[i]  <= '0;
            note_q[i] <= '0;
            vel_q[i]  <= '0;
            left_q[i] <= '0;
         end
         out_valid_q <= 1'b0;
         out_on_q    <= 1'b0;
         out_note_q  <= '0;
         out_vel_q   <= '0;
         out_echo_q  <= 1'b0;
         drop_q      <= '0;
      end else begin
         now_q       <= now_d;
         valid_q     <= valid_d;
         on_q        <= on_d;
         due_q       <= due_d;
         note_q      <= note_d;
         vel_q       <= vel_d;
         left_q      <= left_d;
         out_valid_q <= out_valid_d;
         out_on_q    <= out_on_d;
         out_note_q  <= out_note_d;
         out_vel_q   <= out_vel_d;
         out_echo_q  <= out_echo_d;
         drop_q      <= drop_d;
      end
   end

   assign ev_ready  = en && slot_free;
   assign out_valid = out_valid_q;
   assign out_on    = out_on_q;
   assign out_note  = out_note_q;
   assign out_vel   = out_vel_q;
   assign out_echo  = out_echo_q;
   assign drop_cnt  = drop_q;

endmodule
